phy_ref_lock_seq: RTL and testbench



---
 rtl/phy_ref_lock_pkg.sv | 14 +
 rtl/phy_sync_bit.sv | 15 +
 rtl/phy_ref_lock_seq.sv | 100 ++++++++++
 tb/tb_phy_ref_lock_seq.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/phy_ref_lock_pkg.sv
// phy_ref_lock_pkg: state encoding and loss-counter sizing for the phaser reference lock sequencer
package phy_ref_lock_pkg;
  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_WAIT  = 3'd1,
    S_REL   = 3'd2,
    S_RDY   = 3'd3,
    S_LOST  = 3'd4,
    S_FAIL  = 3'd5,
    S_PDOWN = 3'd6
  } state_t;
  localparam int LOSS_W = 8;
  localparam logic [LOSS_W-1:0] LOSS_MAX = '1;
endpackage

// File: rtl/phy_sync_bit.sv
// phy_sync_bit: multi-flop synchronizer for a single asynchronous bit, cleared by async reset
module phy_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_sync <= '0;
    else r_sync <= {r_sync[STAGES-2:0], i_d};
  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/phy_ref_lock_seq.sv
// phy_ref_lock_seq: PHASER_REF lock-acquisition sequencer driving phaser reset/power-down and PHY reset release
module phy_ref_lock_seq
  import phy_ref_lock_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STABLE_CYCLES  = 64,
  parameter int RELEASE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_locked_in,
  input  logic              i_pwrdwn_req,
  input  logic              i_retry,
  output logic              o_phaser_ref_rst,
  output logic              o_phaser_ref_pwrdwn,
  output logic              o_phy_rst,
  output logic              o_ready,
  output logic              o_timeout,
  output logic [LOSS_W-1:0] o_loss_cnt,
  output logic [2:0]        o_state
);
  localparam int DMAX = (HOLD_CYCLES > STABLE_CYCLES)
                      ? ((HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES)
                      : ((STABLE_CYCLES > RELEASE_CYCLES) ? STABLE_CYCLES : RELEASE_CYCLES);
  localparam int DW = $clog2(DMAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t            r_state, w_state_nx;
  logic [DW-1:0]     r_cnt, w_cnt_nx;
  logic [TW-1:0]     r_tcnt, w_tcnt_nx, w_tcnt_inc;
  logic [LOSS_W-1:0] r_loss;
  logic              r_timeout, r_prr, r_pd, r_phy, r_rdy;
  logic              w_lk, w_hold_done, w_stable_done, w_rel_done, w_to, w_counting;

  phy_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_locked_in),
    .o_q   (w_lk)
  );

  assign w_hold_done   = r_cnt == DW'(HOLD_CYCLES - 1);
  assign w_stable_done = r_cnt == DW'(STABLE_CYCLES - 1);
  assign w_rel_done    = r_cnt == DW'(RELEASE_CYCLES - 1);
  assign w_tcnt_inc    = r_tcnt + 1'b1;
  assign w_to          = w_tcnt_inc >= TW'(TIMEOUT_CYCLES);
  assign w_counting    = r_state inside {S_HOLD, S_WAIT, S_REL};

  // Lock loss beats a completing count; power-down beats everything.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_HOLD:  w_state_nx = w_hold_done ? S_WAIT : S_HOLD;
      S_WAIT:  w_state_nx = (w_lk && w_stable_done) ? S_REL : w_to ? S_FAIL : S_WAIT;
      S_REL:   w_state_nx = !w_lk ? S_LOST : w_rel_done ? S_RDY : S_REL;
      S_RDY:   w_state_nx = !w_lk ? S_LOST : S_RDY;
      S_LOST:  w_state_nx = S_HOLD;
      S_FAIL:  w_state_nx = i_retry ? S_HOLD : S_FAIL;
      default: w_state_nx = S_HOLD;
    endcase
    if (i_pwrdwn_req) w_state_nx = S_PDOWN;
    w_cnt_nx  = (w_state_nx == r_state && w_counting && !(r_state == S_WAIT && !w_lk))
              ? DW'(r_cnt + 1'b1) : '0;
    w_tcnt_nx = (r_state == S_WAIT && w_state_nx == S_WAIT) ? w_tcnt_inc : '0;
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_state   <= S_HOLD;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_loss    <= '0;
      r_timeout <= 1'b0;
      r_prr     <= 1'b1;
      r_pd      <= 1'b0;
      r_phy     <= 1'b1;
      r_rdy     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_tcnt    <= w_tcnt_nx;
      r_loss    <= (w_state_nx == S_LOST && r_loss != LOSS_MAX) ? r_loss + 1'b1 : r_loss;
      r_timeout <= (w_state_nx == S_FAIL) ? 1'b1
                 : (r_state == S_FAIL && w_state_nx == S_HOLD) ? 1'b0 : r_timeout;
      r_prr     <= w_state_nx inside {S_HOLD, S_FAIL, S_PDOWN};
      r_pd      <= w_state_nx == S_PDOWN;
      r_phy     <= w_state_nx != S_RDY;
      r_rdy     <= w_state_nx == S_RDY;
    end

  assign o_phaser_ref_rst    = r_prr;
  assign o_phaser_ref_pwrdwn = r_pd;
  assign o_phy_rst           = r_phy;
  assign o_ready             = r_rdy;
  assign o_timeout           = r_timeout;
  assign o_loss_cnt          = r_loss;
  assign o_state             = r_state;
endmodule

// File: tb/tb_phy_ref_lock_seq.sv
// tb_phy_ref_lock_seq: scoreboard bench; every state change is checked against a queued expected record
module tb_phy_ref_lock_seq;
  logic       clk = 0, rst = 1, locked = 0, pwr = 0, retry = 0;
  logic       o_prr, o_pd, o_phy, o_rdy, o_to;
  logic [7:0] o_lc;
  logic [2:0] o_state;
  logic [15:0] act;

  typedef struct {logic [15:0] v; int dt;} exp_t;
  exp_t q[$];
  int pass_cnt = 0, total = 0, cyc = 0, last = 0;
  logic [2:0] prev = 0;

  always #5 clk = ~clk;

  phy_ref_lock_seq #(
    .SYNC_STAGES(2), .HOLD_CYCLES(16), .STABLE_CYCLES(64),
    .RELEASE_CYCLES(16), .TIMEOUT_CYCLES(200)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_locked_in(locked), .i_pwrdwn_req(pwr), .i_retry(retry),
    .o_phaser_ref_rst(o_prr), .o_phaser_ref_pwrdwn(o_pd), .o_phy_rst(o_phy),
    .o_ready(o_rdy), .o_timeout(o_to), .o_loss_cnt(o_lc), .o_state(o_state)
  );

  assign act = {o_state, o_prr, o_pd, o_phy, o_rdy, o_to, o_lc};

  // {state, phaser_rst, pwrdwn, phy_rst, ready, timeout, loss_cnt}
  function automatic logic [15:0] pk(input logic [2:0] st, input logic to, input logic [7:0] lc);
    logic prr;
    prr = (st == 3'd0) || (st == 3'd5) || (st == 3'd6);
    return {st, prr, st == 3'd6, st != 3'd3, st == 3'd3, to, lc};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
  endtask

  task automatic push(input logic [2:0] st, input logic to, input logic [7:0] lc, input int dt);
    exp_t e;
    e.v = pk(st, to, lc);
    e.dt = dt;
    q.push_back(e);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (o_state !== s && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (o_state !== s) begin
      total++;
      $display("FAIL wait_state: state %0d never reached %0d within %0d cycles", o_state, s, budget);
    end
  endtask

  task automatic reset_dut(input logic lk);
    @(posedge clk); #1;
    locked = lk;
    rst = 1;
    #1 chk("rst_outputs", act, pk(3'd0, 1'b0, 8'd0));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst = 0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk); cyc++; #1;
      if (rst) begin
        prev = o_state;
        last = cyc;
      end else if (o_state !== prev) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_transition: got state %0d outputs %0h, expected none", o_state, act);
        end else begin
          e = q.pop_front();
          chk("trans", act, e.v);
          if (e.dt >= 0) chk("trans_dt", cyc - last, e.dt);
        end
        prev = o_state;
        last = cyc;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // clean lock, then RETRY while READY is ignored
    push(1, 0, 0, 16); push(2, 0, 0, 64); push(3, 0, 0, 16);
    reset_dut(1);
    wait_state(3, 200);
    retry = 1; ticks(1); retry = 0; ticks(3);
    chk("retry_ignored", o_state, 3);
    // lock loss in READY for 5 cycles
    push(4, 0, 1, 7); push(0, 0, 1, 1); push(1, 0, 1, 16); push(2, 0, 1, 64); push(3, 0, 1, 16);
    locked = 0; ticks(5); locked = 1;
    wait_state(3, 300);
    // power-down from READY, relock afterwards
    push(6, 0, 1, 1); push(0, 0, 1, 10); push(1, 0, 1, 16); push(2, 0, 1, 64); push(3, 0, 1, 16);
    pwr = 1; ticks(10); pwr = 0;
    wait_state(3, 300);
    // glitch at stable count 40 restarts the stable count
    push(1, 0, 0, 16); push(2, 0, 0, 105); push(3, 0, 0, 16);
    reset_dut(1);
    ticks(54); locked = 0; ticks(1); locked = 1;
    wait_state(3, 300);
    // timeout, sticky flag, power-down together with RETRY
    push(1, 0, 0, 16); push(5, 1, 0, 200);
    reset_dut(0);
    wait_state(5, 300);
    ticks(20);
    chk("timeout_sticky", {o_state, o_to}, {3'd5, 1'b1});
    push(6, 1, 0, 21); push(0, 1, 0, 5); push(1, 1, 0, 16); push(5, 1, 0, 200);
    pwr = 1; retry = 1; ticks(1); retry = 0; ticks(4); pwr = 0;
    wait_state(6, 1);
    wait_state(5, 300);
    push(0, 0, 0, 1); push(1, 0, 0, 16); push(2, 0, 0, 64); push(3, 0, 0, 16);
    retry = 1; locked = 1; ticks(1); retry = 0;
    wait_state(3, 300);
    // 260 loss events from RELEASE saturate the counter
    push(1, 0, 0, 16); push(2, 0, 0, 64);
    reset_dut(1);
    wait_state(2, 200);
    for (int i = 1; i <= 260; i++) begin
      push(4, 0, (i > 255) ? 8'd255 : 8'(i), 3); push(0, 0, (i > 255) ? 8'd255 : 8'(i), 1);
      push(1, 0, (i > 255) ? 8'd255 : 8'(i), 16); push(2, 0, (i > 255) ? 8'd255 : 8'(i), 64);
      locked = 0; ticks(1); locked = 1;
      wait_state(0, 10);
      wait_state(2, 200);
    end
    chk("loss_sat", o_lc, 255);
    // async reset mid-RELEASE clears everything before the next edge
    ticks(5);
    rst = 1;
    #1 chk("midrel_rst", act, pk(3'd0, 1'b0, 8'd0));
    push(1, 0, 0, 16); push(2, 0, 0, 64); push(3, 0, 0, 16);
    @(posedge clk); @(posedge clk); @(negedge clk) rst = 0;
    wait_state(3, 200);
    ticks(2);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
